// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the memory port-A arbiter.
package mem_arb_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;

   localparam logic [ADDR_W-1:0] PROT_TOP_DEF = 12'h200;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CPU  = 2'd1,
      LDR  = 2'd2
   } rd_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the arbiter: one instance each for the CPU and the loader.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic              req;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, write, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, write, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of CPU wins while the loader waits; at_limit hands the next contested cycle to the loader.
module arb_starve_ctr #(
   parameter int  LIMIT = 4,
   localparam int W     = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_limit
);

   logic [W-1:0] r_cnt;
   logic         w_at_limit;

   assign w_at_limit = (r_cnt == W'(LIMIT));
   assign o_at_limit = w_at_limit;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_at_limit) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Port-A arbiter between CPU (fixed priority) and program loader, with starvation guard,
// loader lock, loader write protection of the low region, and read-return routing.
//
//   rd_owner | meaning
//   NONE     | no read issued last cycle; no rvalid this cycle
//   CPU      | CPU read issued last cycle; mem_rdata belongs to CPU
//   LDR      | loader read issued last cycle; mem_rdata belongs to loader
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int                STARVE_LIMIT = 4,
   parameter logic [ADDR_W-1:0] PROT_TOP     = PROT_TOP_DEF
) (
   input  logic              clk,
   input  logic              reset,
   mem_arbiter_if.slave      cpu,
   mem_arbiter_if.slave      ldr,
   input  logic              ldr_lock,
   output logic              prot_err,
   output logic              mem_en,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   rd_owner_t r_rd_owner;
   rd_owner_t w_rd_owner_nxt;
   logic      r_prot_err;
   logic      w_cpu_win;
   logic      w_ldr_win;
   logic      w_ldr_prot;
   logic      w_at_limit;

   arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk        (clk),
      .reset      (reset),
      .i_inc      (w_cpu_win && ldr.req && !ldr_lock),
      .i_clr      (w_ldr_win || !ldr.req),
      .o_at_limit (w_at_limit)
   );

   always_comb begin
      w_cpu_win = 1'b0;
      w_ldr_win = 1'b0;
      if (!reset) begin
         if (ldr.req && (ldr_lock || (cpu.req && w_at_limit))) begin
            w_ldr_win = 1'b1;
         end else if (cpu.req) begin
            w_cpu_win = 1'b1;
         end else if (ldr.req) begin
            w_ldr_win = 1'b1;
         end
      end
   end

   // A dropped loader write is still granted so the loader moves on.
   assign w_ldr_prot = w_ldr_win && ldr.write && (ldr.addr < PROT_TOP);

   assign cpu.gnt   = w_cpu_win;
   assign ldr.gnt   = w_ldr_win;
   assign mem_en    = w_cpu_win || (w_ldr_win && !w_ldr_prot);
   assign mem_write = w_cpu_win ? cpu.write : (w_ldr_win && !w_ldr_prot && ldr.write);
   assign mem_addr  = w_ldr_win ? ldr.addr  : cpu.addr;
   assign mem_wdata = w_ldr_win ? ldr.wdata : cpu.wdata;

   always_comb begin
      w_rd_owner_nxt = NONE;
      if (w_cpu_win && !cpu.write) begin
         w_rd_owner_nxt = CPU;
      end else if (w_ldr_win && !ldr.write) begin
         w_rd_owner_nxt = LDR;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_owner <= NONE;
         r_prot_err <= 1'b0;
      end else begin
         r_rd_owner <= w_rd_owner_nxt;
         r_prot_err <= w_ldr_prot;
      end
   end

   // Gated by reset so a read granted just before reset never returns.
   assign cpu.rvalid = !reset && (r_rd_owner == CPU);
   assign ldr.rvalid = !reset && (r_rd_owner == LDR);
   assign prot_err   = !reset && r_prot_err;
   assign cpu.rdata  = mem_rdata;
   assign ldr.rdata  = mem_rdata;

endmodule
